// File: rtl/hdmi_gearbox.sv
// hdmi_gearbox
// -------------
// This block converts full encoded words into fixed-width slices. It feeds the
// per-lane serializers one OUT_WIDTH slice per channel on every gclk, with no gaps.
// Words arrive through a valid/ready handshake and wait in a small FIFO that
// holds one entry per accepted beat, covering all channels. At each word
// boundary the block loads the next word from one of three sources, in this order:
//   1. TRAIN_WORD, while train is high.
//   2. The FIFO head, if the FIFO holds a word.
//   3. IDLE_WORD otherwise. This case also sets the sticky underflow flag.
//
// Ports
//   gclk        slice-rate clock
//   rst_n       asynchronous active-low reset
//   in_data     CHANNELS*IN_WIDTH input word, channel c at [c*IN_WIDTH +: IN_WIDTH]
//   in_valid    in_data valid
//   in_ready    FIFO not full (combinational)
//   train       force TRAIN_WORD at word boundaries, FIFO left untouched
//   clr_err     clear the underflow flag
//   out_d       registered slices, channel c at [c*OUT_WIDTH +: OUT_WIDTH]
//   out_start   high while out_d carries slice 0 of a word
//   underflow   sticky idle-insertion flag
//   fifo_level  current FIFO occupancy
module hdmi_gearbox #(
  parameter int                  CHANNELS   = 3,
  parameter int                  IN_WIDTH   = 10,
  parameter int                  OUT_WIDTH  = 5,
  parameter int                  DEPTH      = 4,
  parameter logic [IN_WIDTH-1:0] IDLE_WORD  = 10'h354,
  parameter logic [IN_WIDTH-1:0] TRAIN_WORD = 10'h0AB
) (
  input  logic                            gclk,
  input  logic                            rst_n,
  input  logic [CHANNELS*IN_WIDTH-1:0]    in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            train,
  input  logic                            clr_err,
  output logic [CHANNELS*OUT_WIDTH-1:0]   out_d,
  output logic                            out_start,
  output logic                            underflow,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_level
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int WW    = CHANNELS * IN_WIDTH;
  localparam int SW    = CHANNELS * OUT_WIDTH;

  localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [WW-1:0] IDLE_ALL   = {CHANNELS{IDLE_WORD}};
  localparam logic [WW-1:0] TRAIN_ALL  = {CHANNELS{TRAIN_WORD}};

  typedef enum logic [1:0] {
    SRC_TRAIN,
    SRC_FIFO,
    SRC_IDLE
  } src_e;

  // State
  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [WW-1:0] cur_word_q, cur_word_d;
  logic          fresh_q;
  logic [SW-1:0] out_d_q, out_d_d;
  logic          out_start_q, out_start_d;
  logic          underflow_q, underflow_d;

  // Combinational helpers
  logic          push;
  logic          pop;
  logic          load;
  src_e          src;
  logic [WW-1:0] next_word;
  logic [WW-1:0] emit_word;
  logic [OUT_WIDTH-1:0] slices [CHANNELS][RATIO];

  assign in_ready   = (level_q != FULL_LEVEL);
  assign out_d      = out_d_q;
  assign out_start  = out_start_q;
  assign underflow  = underflow_q;
  assign fifo_level = level_q;

  // The first edge after reset has no load boundary ahead of it. If train is
  // already high at that edge, the training word replaces the reset idle word
  // right away, so the first slice 0 on the wire is already a training slice.
  assign emit_word = (fresh_q && train) ? TRAIN_ALL : cur_word_q;

  // View the emitted word as [channel][slice] so the phase counter can pick
  // a slice with a plain array index.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar k = 0; k < RATIO; k++) begin : g_sl
      assign slices[c][k] = emit_word[c*IN_WIDTH + k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // NOTE: every signal written here gets a default assignment first. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    push        = in_valid & in_ready;
    load        = (phase_q == LAST_PHASE);
    src         = SRC_IDLE;
    next_word   = IDLE_ALL;
    pop         = 1'b0;
    out_d_d     = '0;
    out_start_d = (phase_q == '0);
    phase_d     = phase_q + PW'(1);
    cur_word_d  = emit_word;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;

    // Pick the source from the pre-edge level. A word pushed on this same edge
    // is therefore not eligible until the next boundary.
    if (train)              src = SRC_TRAIN;
    else if (level_q != '0) src = SRC_FIFO;
    else                    src = SRC_IDLE;

    case (src)
      SRC_TRAIN: next_word = TRAIN_ALL;
      SRC_FIFO:  next_word = mem_q[rd_ptr_q];
      default:   next_word = IDLE_ALL;
    endcase

    for (int c = 0; c < CHANNELS; c++) begin
      out_d_d[c*OUT_WIDTH +: OUT_WIDTH] = slices[c][phase_q];
    end

    if (load) begin
      phase_d    = '0;
      cur_word_d = next_word;
      pop        = (src == SRC_FIFO);
      // If clr_err arrives on the same edge as an idle insertion, the set wins.
      if (src == SRC_IDLE) underflow_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      phase_q     <= '0;
      cur_word_q  <= IDLE_ALL;
      fresh_q     <= 1'b1;
      out_d_q     <= '0;
      out_start_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      phase_q     <= phase_d;
      cur_word_q  <= cur_word_d;
      fresh_q     <= 1'b0;
      out_d_q     <= out_d_d;
      out_start_q <= out_start_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the FIFO storage has no reset. The level and the pointers alone decide
  // which entries are valid, so stale contents are never read.
  always_ff @(posedge gclk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_hdmi_gearbox.sv
// Testbench for hdmi_gearbox.
// The default instance (3 lanes, 10-bit words, 5-bit slices) is checked on
// every cycle against a word-stream model: a queue of accepted words, plus the
// word currently being sliced. Directed literal checks pin the model as well.
// A second instance (1 lane, 8-bit words, 2-bit slices) is checked with
// hand-computed slice sequences.
module tb_hdmi_gearbox;

  localparam int CH    = 3;
  localparam int IW    = 10;
  localparam int OW    = 5;
  localparam int DEP   = 4;
  localparam int RATIO = IW / OW;
  localparam int WW    = CH * IW;
  localparam int SW    = CH * OW;
  localparam logic [IW-1:0] IDLE_W  = 10'h354;
  localparam logic [IW-1:0] TRAIN_W = 10'h0AB;

  logic          gclk = 1'b0;
  logic          rst_n = 1'b1;
  logic [WW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          train = 1'b0;
  logic          clr_err = 1'b0;
  logic [SW-1:0] out_d;
  logic          out_start;
  logic          underflow;
  logic [2:0]    fifo_level;

  logic [7:0]    in_data2 = '0;
  logic          in_valid2 = 1'b0;
  logic          in_ready2;
  logic [1:0]    out_d2;
  logic          out_start2;
  logic          underflow2;
  logic [2:0]    fifo_level2;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 gclk = ~gclk;

  hdmi_gearbox dut (
    .gclk(gclk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .train(train), .clr_err(clr_err), .out_d(out_d),
    .out_start(out_start), .underflow(underflow), .fifo_level(fifo_level)
  );

  hdmi_gearbox #(
    .CHANNELS(1), .IN_WIDTH(8), .OUT_WIDTH(2), .DEPTH(4),
    .IDLE_WORD(8'hE4), .TRAIN_WORD(8'h1B)
  ) dut2 (
    .gclk(gclk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .train(1'b0), .clr_err(1'b0), .out_d(out_d2),
    .out_start(out_start2), .underflow(underflow2), .fifo_level(fifo_level2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Word-stream model. Each word on the wire lasts RATIO cycles, sent slice 0
  // first. At each word boundary the next word is the training word, or else
  // the oldest queued word, or else the idle word (which raises the error flag).
  // ---------------------------------------------------------------------------
  logic [WW-1:0] m_q [$];
  logic [WW-1:0] m_cur;
  logic [WW-1:0] m_word;
  int            m_phase;
  bit            m_fresh;
  bit            m_push;
  logic [SW-1:0] e_out;
  bit            e_start;
  bit            e_under;

  always @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cur   = {CH{IDLE_W}};
      m_phase = 0;
      m_fresh = 1'b1;
      e_out   = '0;
      e_start = 1'b0;
      e_under = 1'b0;
    end else begin
      m_push = in_valid && (m_q.size() < DEP);
      m_word = in_data;
      if (m_fresh && train) m_cur = {CH{TRAIN_W}};
      m_fresh = 1'b0;
      for (int c = 0; c < CH; c++) e_out[c*OW +: OW] = m_cur[c*IW + m_phase*OW +: OW];
      e_start = (m_phase == 0);
      if (clr_err) e_under = 1'b0;
      if (m_phase == RATIO - 1) begin
        m_phase = 0;
        if (train) m_cur = {CH{TRAIN_W}};
        else if (m_q.size() > 0) m_cur = m_q.pop_front();
        else begin
          m_cur   = {CH{IDLE_W}};
          e_under = 1'b1;
        end
      end else begin
        m_phase++;
      end
      if (m_push) m_q.push_back(m_word);
    end
  end

  always @(negedge gclk) begin
    if (check_en) begin
      check("out_d", 32'(out_d), 32'(e_out));
      check("out_start", 32'(out_start), 32'(e_start));
      check("underflow", 32'(underflow), 32'(e_under));
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check("in_ready", 32'(in_ready), 32'(m_q.size() < DEP));
    end
  end

  task automatic wait_start(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge gclk);
      if (out_start) found = 1'b1;
    end
    if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_start2(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge gclk);
      if (out_start2) found = 1'b1;
    end
    if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit found;
    int exp_s [8];
    int exp_st [8];
    exp_s  = '{1, 2, 3, 0, 3, 1, 2, 0};
    exp_st = '{0, 0, 0, 1, 0, 0, 0, 1};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge gclk);
    check("rst_out_d", 32'(out_d), 32'd0);
    check("rst_out_start", 32'(out_start), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Idle pattern: 10'h354 gives slices 5'h14, 5'h1A
    @(negedge gclk);
    check("idle_s0_ch0", 32'(out_d[4:0]), 32'h14);
    check("idle_s0_ch2", 32'(out_d[14:10]), 32'h14);
    check("idle_s0_start", 32'(out_start), 32'd1);
    check("idle_s0_under", 32'(underflow), 32'd0);
    @(negedge gclk);
    check("idle_s1_ch0", 32'(out_d[4:0]), 32'h1A);
    check("idle_s1_start", 32'(out_start), 32'd0);
    check("idle_s1_under", 32'(underflow), 32'd1);
    repeat (3) @(negedge gclk);

    // A single word {155, 000, 3FF} injected while idling
    in_valid = 1'b1;
    in_data  = {10'h155, 10'h000, 10'h3FF};
    @(negedge gclk);
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (out_start && out_d[4:0] == 5'h1F) found = 1'b1;
      else @(negedge gclk);
    end
    check("word_seen", 32'(found), 32'd1);
    check("word_s0_ch1", 32'(out_d[9:5]), 32'h00);
    check("word_s0_ch2", 32'(out_d[14:10]), 32'h15);
    @(negedge gclk);
    check("word_s1_ch0", 32'(out_d[4:0]), 32'h1F);
    check("word_s1_ch2", 32'(out_d[14:10]), 32'h0A);
    @(negedge gclk);
    check("idle_resume_ch0", 32'(out_d[4:0]), 32'h14);
    check("idle_resume_start", 32'(out_start), 32'd1);

    // Streaming without drain until the FIFO fills
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = {10'(i * 37 + 3), 10'(i * 91 + 7), 10'(i * 13 + 1)};
      @(negedge gclk);
    end
    check("stream_full_level", 32'(fifo_level), 32'd4);
    check("stream_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (12) @(negedge gclk);
    check("stream_drained_level", 32'(fifo_level), 32'd0);
    check("stream_drained_ready", 32'(in_ready), 32'd1);

    // Training with two words queued
    wait_start("train_align");
    in_valid = 1'b1;
    in_data  = {10'h111, 10'h222, 10'h333};
    @(negedge gclk);
    in_data  = {10'h0F0, 10'h30C, 10'h2AA};
    train    = 1'b1;
    @(negedge gclk);
    in_valid = 1'b0;
    repeat (4) @(negedge gclk);
    check("train_level", 32'(fifo_level), 32'd2);
    wait_start("train_s0");
    check("train_s0_ch0", 32'(out_d[4:0]), 32'h0B);
    check("train_s0_ch1", 32'(out_d[9:5]), 32'h0B);
    @(negedge gclk);
    check("train_s1_ch0", 32'(out_d[4:0]), 32'h05);
    train = 1'b0;
    repeat (10) @(negedge gclk);

    // clr_err with the FIFO supplying words, then coincident with idle insertion
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {10'(i + 5), 10'(i + 6), 10'(i + 7)};
      @(negedge gclk);
    end
    in_valid = 1'b0;
    clr_err  = 1'b1;
    @(negedge gclk);
    clr_err  = 1'b0;
    check("clr_cleared", 32'(underflow), 32'd0);
    clr_err  = 1'b1;
    @(negedge gclk);
    clr_err  = 1'b0;
    check("clr_no_pending", 32'(underflow), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge gclk);
      if (fifo_level == 0 && out_start) found = 1'b1;
    end
    check("clr_align_found", 32'(found), 32'd1);
    check("clr_before_idle", 32'(underflow), 32'd0);
    clr_err = 1'b1;
    @(negedge gclk);
    clr_err = 1'b0;
    check("clr_set_wins", 32'(underflow), 32'd1);

    // Asynchronous reset with three words queued
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge gclk);
      if (fifo_level == 3) found = 1'b1;
      else begin
        in_valid = 1'b1;
        in_data  = {10'(i + 40), 10'(i + 50), 10'(i + 60)};
      end
    end
    in_valid = 1'b0;
    check("level3_reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_d", 32'(out_d), 32'd0);
    check("arst_out_start", 32'(out_start), 32'd0);
    check("arst_underflow", 32'(underflow), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
    check("arst_rel_ch0", 32'(out_d[4:0]), 32'h14);
    check("arst_rel_start", 32'(out_start), 32'd1);
    check("arst_rel_level", 32'(fifo_level), 32'd0);

    // 8-bit word, 2-bit slices: idle 8'hE4 -> 0,1,2,3; data 8'h9C -> 0,3,1,2
    wait_start2("sweep_align");
    check("sweep_idle_s0", 32'(out_d2), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge gclk);
      check("sweep_idle_sk", 32'(out_d2), 32'(k));
      check("sweep_idle_stk", 32'(out_start2), 32'd0);
    end
    @(negedge gclk);
    check("sweep_idle_start", 32'(out_start2), 32'd1);
    in_valid2 = 1'b1;
    in_data2  = 8'h9C;
    for (int i = 0; i < 8; i++) begin
      @(negedge gclk);
      if (i == 0) in_valid2 = 1'b0;
      check("sweep_slice", 32'(out_d2), 32'(exp_s[i]));
      check("sweep_start", 32'(out_start2), 32'(exp_st[i]));
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
